marker_tracker: RTL
===================

# marker_tracker

Per-frame centroid and size tracker for one colour marker. Consumes the pipelined threshold mask stream (pixel coordinate plus mask bit), accumulates coordinate sums and pixel count over a frame, then runs a multi-cycle sequential divide to produce a 12/12/14-bit (x, y, z) marker position. The result drives one set of hand/head ports of game_logic_and_renderer, for example hand_x_left_top, hand_y_left_top and hand_z_left_top. One instance is built per tracked marker.

## Interface
Parameters:
- MIN_COUNT, 64: minimum masked pixels per frame for a valid detection.
- Z_SHIFT, 4: right shift applied to the pixel count to form z.

Ports:
- clk_in, input, 1: system clock (clk_65mhz domain).
- rst_in, input, 1: asynchronous, active-low reset.
- x_in, input, 11: pixel column, pipelined to align with valid_in.
- y_in, input, 10: pixel row, aligned with valid_in.
- valid_in, input, 1: threshold mask bit for this pixel.
- tabulate_in, input, 1: one-cycle frame-boundary pulse.
- x_out, output, 12: centroid column, zero-extended.
- y_out, output, 12: centroid row, zero-extended.
- z_out, output, 14: size/depth estimate.
- found_out, output, 1: level; 1 if the last completed frame met MIN_COUNT.
- valid_out, output, 1: one-cycle pulse when the outputs update.
- busy_out, output, 1: high while in DIVIDE or DONE.

## Operation
- Accumulators:
  - sum_x is 32-bit, sum_y is 32-bit, count is 20-bit (1024×768 fits in 20 bits).
  - Each cycle with valid_in=1: sum_x += x_in, sum_y += y_in, count += 1.
- On tabulate_in:
  - The accumulators are snapshotted into the divider inputs and cleared.
  - A valid_in pixel in the same cycle belongs to the new frame: the accumulators load {x_in, y_in, 1} instead of 0.
- FSM (IDLE, DIVIDE, DONE):
  - IDLE → DIVIDE on tabulate_in when the snapshot count ≥ MIN_COUNT.
  - IDLE → IDLE on tabulate_in when count < MIN_COUNT. found_out ← 0, x/y/z hold, no valid_out.
  - DIVIDE: two seq_divider instances run in parallel, computing sum_x/count and sum_y/count. They are unsigned restoring dividers, 32 iterations at one quotient bit per cycle.
  - DIVIDE → DONE when the iteration counter reaches 31.
  - DONE: registers the results and goes to IDLE.
- Result writes:
  - x_out ← quotient_x[11:0] and y_out ← quotient_y[11:0]; quotients are floored.
  - z_out ← min(count >> Z_SHIFT, 16383), saturating.
  - found_out ← 1, valid_out ← 1.
- tabulate_in while busy: the accumulators clear and restart as normal, but that snapshot is discarded. The in-flight divide completes unaffected.
- Division by zero cannot occur because MIN_COUNT ≥ 1 is required; a parameter check is enforced at elaboration.

## Timing
- Reset (rst_in=0, asynchronous): every output is 0, all accumulators are 0, and the FSM is in IDLE. Deassertion is synchronised internally with a 2-flop synchroniser.
- Latency, with tabulate_in high in cycle T:
  - Snapshot is taken at the end of T.
  - DIVIDE occupies T+1 through T+32.
  - DONE occupies T+33.
  - x/y/z/found_out update and valid_out pulses in T+34.
- valid_out is high for exactly one cycle. There is no back-pressure; consumers sample on valid_out or read the held outputs at any time.
- busy_out is high from T+1 through T+33 inclusive.
- Reset asserted mid-DIVIDE aborts immediately: outputs go to 0 and no valid_out pulse follows.
- Throughput is one result per frame. Frame spacing (~800k cycles) far exceeds the 34-cycle latency.

## Structure
- tracker_pkg holds:
  - the state enum (IDLE, DIVIDE, DONE);
  - width constants: SUM_W=32, CNT_W=20, XO_W=12, ZO_W=14.
- Sub-module seq_divider (clk_in, rst_in, start_in, dividend_in[31:0], divisor_in[19:0], quotient_out[31:0], done_out) is instantiated twice. Its remainder is unused.
- The top level contains the accumulators, the snapshot registers, the FSM and the z saturation.

## Test plan
- Centroid of a square: 8×8 mask block at x 200–207, y 100–107, then tabulate at T → valid_out in T+34 with x_out=203, y_out=103, z_out=4, found_out=1.
- Below threshold: 63 masked pixels, then tabulate → no valid_out. found_out=0; x/y/z hold their previous values (e.g. 203/103/4).
- Full frame with z saturation: every pixel of 1024×768 masked → x_out=511, y_out=383, z_out=16383.
- Pixel on the tabulate cycle: valid_in=1 at (10,20) together with tabulate_in, plus 63 more pixels at (10,20) in the next frame → next result x_out=10, y_out=20, z_out=4.
- Tabulate while busy: a second tabulate at T+5 → the first result still arrives at T+34, and the second snapshot produces no result.
- Reset mid-divide: rst_in low at T+10 → all outputs 0 asynchronously. After release, no valid_out pulse occurs and the FSM is in IDLE.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types and widths for the colour-marker tracker.
// The z saturation helper lives here so the top stays focused on control.
package tracker_pkg;

  localparam int SUM_W  = 32;
  localparam int CNT_W  = 20;
  localparam int XO_W   = 12;
  localparam int ZO_W   = 14;
  localparam int ITER_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Scale the pixel count down and clamp it to the z port range.
  function automatic logic [ZO_W-1:0] sat_z(input logic [CNT_W-1:0] cnt, input int shift);
    logic [CNT_W-1:0] s;
    s = cnt >> shift;
    if (|s[CNT_W-1:ZO_W]) return '1;
    return s[ZO_W-1:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over 32 cycles.
// The dividend register shifts left and collects quotient bits at its LSB.
module seq_divider
  import tracker_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [SUM_W-1:0] dividend_in,
  input  logic [CNT_W-1:0] divisor_in,
  output logic [SUM_W-1:0] quotient_out,
  output logic             done_out
);

  logic              r_busy;
  logic [ITER_W-1:0] r_iter;
  logic [SUM_W-1:0]  r_q;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div;

  logic [CNT_W:0]    w_trial;
  logic [CNT_W:0]    w_diff;
  logic              w_fits;

  assign w_trial = {r_rem, r_q[SUM_W-1]};
  assign w_fits  = (w_trial >= {1'b0, r_div});
  assign w_diff  = w_trial - {1'b0, r_div};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy <= 1'b0;
      r_iter <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (start_in) begin
      r_busy <= 1'b1;
      r_iter <= '0;
      r_q    <= dividend_in;
      r_rem  <= '0;
      r_div  <= divisor_in;
    end else if (r_busy) begin
      // A trial value that fails the compare is below the divisor, so its MSB is 0.
      r_q    <= {r_q[SUM_W-2:0], w_fits};
      r_rem  <= w_fits ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
      r_iter <= r_iter + ITER_W'(1);
      if (r_iter == '1) r_busy <= 1'b0;
    end
  end

  assign done_out     = r_busy && (r_iter == '1);
  assign quotient_out = r_q;

endmodule

// File: rtl/marker_tracker.sv
// Per-frame centroid and size tracker for one colour marker: accumulates masked
// pixel coordinates, then divides the sums by the count after each frame boundary.
module marker_tracker
  import tracker_pkg::*;
#(
  parameter int MIN_COUNT = 64,
  parameter int Z_SHIFT   = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [10:0]     x_in,
  input  logic [9:0]      y_in,
  input  logic            valid_in,
  input  logic            tabulate_in,
  output logic [XO_W-1:0] x_out,
  output logic [XO_W-1:0] y_out,
  output logic [ZO_W-1:0] z_out,
  output logic            found_out,
  output logic            valid_out,
  output logic            busy_out
);

  if (MIN_COUNT < 1 || MIN_COUNT >= (1 << CNT_W)) begin : g_bad_min_count
    $error("MIN_COUNT must be in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MIN_CNT_L = CNT_W'(MIN_COUNT);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [SUM_W-1:0] r_sum_x, r_sum_y;
  logic [CNT_W-1:0] r_count, r_snap_count;
  state_t           r_state, w_next;
  logic             w_start, w_miss, w_commit;
  logic [SUM_W-1:0] w_quot_x, w_quot_y;
  logic             w_done_x, w_done_y;
  logic [XO_W-1:0]  r_x, r_y;
  logic [ZO_W-1:0]  r_z;
  logic             r_found, r_valid;
  logic             w_unused_quot;

  // Assertion is immediate; release is delayed two clocks.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // A pixel arriving with the frame pulse starts the new frame.
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_count <= '0;
    end else if (tabulate_in) begin
      r_sum_x <= valid_in ? SUM_W'(x_in) : '0;
      r_sum_y <= valid_in ? SUM_W'(y_in) : '0;
      r_count <= valid_in ? CNT_W'(1) : '0;
    end else if (valid_in) begin
      r_sum_x <= r_sum_x + SUM_W'(x_in);
      r_sum_y <= r_sum_y + SUM_W'(y_in);
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = DIVIDE;
      DIVIDE:  if (w_done_x && w_done_y) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame pulses seen outside IDLE are dropped; the running divide is untouched.
  always_comb begin
    w_start  = (r_state == IDLE) && tabulate_in && (r_count >= MIN_CNT_L);
    w_miss   = (r_state == IDLE) && tabulate_in && (r_count <  MIN_CNT_L);
    w_commit = (r_state == DONE);
    busy_out = (r_state != IDLE);
  end

  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n)     r_snap_count <= '0;
    else if (w_start) r_snap_count <= r_count;
  end

  seq_divider u_div_x (
    .clk_in       (clk_in),
    .rst_in       (w_rst_n),
    .start_in     (w_start),
    .dividend_in  (r_sum_x),
    .divisor_in   (r_count),
    .quotient_out (w_quot_x),
    .done_out     (w_done_x)
  );

  seq_divider u_div_y (
    .clk_in       (clk_in),
    .rst_in       (w_rst_n),
    .start_in     (w_start),
    .dividend_in  (r_sum_y),
    .divisor_in   (r_count),
    .quotient_out (w_quot_y),
    .done_out     (w_done_y)
  );

  // valid_out is a one-cycle notification with no ready: consumers sample on it or read the held values.
  always_ff @(posedge clk_in or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_found <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_x     <= w_quot_x[XO_W-1:0];
        r_y     <= w_quot_y[XO_W-1:0];
        r_z     <= sat_z(r_snap_count, Z_SHIFT);
        r_found <= 1'b1;
      end else if (w_miss) begin
        r_found <= 1'b0;
      end
    end
  end

  assign w_unused_quot = ^{w_quot_x[SUM_W-1:XO_W], w_quot_y[SUM_W-1:XO_W]};

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign z_out     = r_z;
  assign found_out = r_found;
  assign valid_out = r_valid;

endmodule
